// File: rtl/q_serializer_if.sv
// Q-word handshake bundle for the charge-to-pulse serializer.
// master offers q_in/q_valid; slave answers with q_ready.
interface q_serializer_if #(
    parameter int BUS_WIDTH = 10
);
    logic                 q_valid;
    logic                 q_ready;
    logic [BUS_WIDTH-1:0] q_in;

    modport master (
        output q_valid,
        output q_in,
        input  q_ready
    );

    modport slave (
        input  q_valid,
        input  q_in,
        output q_ready
    );
endinterface

// File: rtl/q_serializer.sv
// Turns a charge word into a train of fixed-width pulses plus a frame gap.
// Optional one-cycle done strobe on frame end: define Q_SERIALIZER_DONE_EN.
module q_serializer #(
    parameter int BUS_WIDTH      = 10,
    parameter int Q_PER_PULSE    = 1,
    parameter int PULSE_DURATION = 3,
    parameter int GAP_DURATION   = 2,
    parameter int FRAME_GAP      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    q_serializer_if.slave        qi,
    output logic                 q_serialized,
    output logic                 busy,
`ifdef Q_SERIALIZER_DONE_EN
    output logic                 done,
`endif
    output logic [BUS_WIDTH-1:0] pulses_sent
);

    localparam int SHIFT = $clog2(Q_PER_PULSE);
    localparam int MAXD0 = (PULSE_DURATION > GAP_DURATION) ?
                           PULSE_DURATION : GAP_DURATION;
    localparam int MAXD  = (MAXD0 > FRAME_GAP) ? MAXD0 : FRAME_GAP;
    localparam int CW    = $clog2(MAXD + 1);

    localparam logic [CW-1:0] P_LAST = CW'(PULSE_DURATION - 1);
    localparam logic [CW-1:0] G_LAST = CW'(GAP_DURATION - 1);
    localparam logic [CW-1:0] F_LAST = CW'(FRAME_GAP - 1);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        FGAP
    } state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [BUS_WIDTH-1:0] target;
    logic                 abort;
    logic [BUS_WIDTH-1:0] tgt_in;
    logic                 more;

    assign tgt_in     = qi.q_in >> SHIFT;
    // Widened compare so the count can reach the all-ones target.
    assign more       = ({1'b0, pulses_sent} + 1'b1) < {1'b0, target};
    assign qi.q_ready = (state == IDLE) && start;

`ifdef Q_SERIALIZER_DONE_EN
    assign done = (state == FGAP) && (cnt == F_LAST);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            target       <= '0;
            abort        <= 1'b0;
            pulses_sent  <= '0;
            q_serialized <= 1'b0;
            busy         <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (qi.q_valid && start) begin
                        target      <= tgt_in;
                        pulses_sent <= '0;
                        cnt         <= '0;
                        abort       <= 1'b0;
                        busy        <= 1'b1;
                        if (tgt_in != '0) begin
                            state        <= HIGH;
                            q_serialized <= 1'b1;
                        end else begin
                            state <= FGAP;
                        end
                    end
                end
                HIGH: begin
                    // A stop request only takes effect once the pulse ends.
                    if (!start) abort <= 1'b1;
                    if (cnt == P_LAST) begin
                        cnt          <= '0;
                        abort        <= 1'b0;
                        q_serialized <= 1'b0;
                        pulses_sent  <= pulses_sent + 1'b1;
                        if (more && start && !abort) state <= LOW;
                        else state <= FGAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LOW: begin
                    if (!start) begin
                        state <= FGAP;
                        cnt   <= '0;
                    end else if (cnt == G_LAST) begin
                        state        <= HIGH;
                        cnt          <= '0;
                        q_serialized <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FGAP: begin
                    if (cnt == F_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    cnt          <= '0;
                    busy         <= 1'b0;
                    q_serialized <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/q_serializer.md
Q_SERIALIZER -- requirements
Module: q_serializer

Interface
REQ-001 The block SHALL have parameter BUS_WIDTH, default 10, giving the width of the Q word and of the pulse counters.
REQ-002 The block SHALL have parameter Q_PER_PULSE, default 1, giving the charge units represented by one pulse; it is a power of two.
REQ-003 The block SHALL have parameter PULSE_DURATION, default 3, giving the high time of each pulse in clk cycles; it is at least 1.
REQ-004 The block SHALL have parameter GAP_DURATION, default 2, giving the low time between pulses in clk cycles; it is at least 1.
REQ-005 The block SHALL have parameter FRAME_GAP, default 8, giving the low time after the last pulse of a frame in clk cycles; it is at least 1.
REQ-006 clk  input  1  The single clock; all state changes on the rising edge.
REQ-007 rst  input  1  Reset; asynchronous, active-low.
REQ-008 start  input  1  Enables frame acceptance; low requests abort of the frame in progress.
REQ-009 q_valid  input  1  A new Q word is offered on q_in.
REQ-010 q_in  input  BUS_WIDTH  Q value to serialize.
REQ-011 q_ready  output  1  The block can accept a word.
REQ-012 q_serialized  output  1  Serial pulse stream, registered.
REQ-013 busy  output  1  A frame is in progress.
REQ-014 pulses_sent  output  BUS_WIDTH  Number of pulses completed in the current or last frame.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, HIGH, LOW and FGAP.
REQ-016 q_ready SHALL equal (state==IDLE && start); a word is accepted on a rising edge where q_valid && q_ready.
REQ-017 On acceptance, the block SHALL latch target = q_in >> log2(Q_PER_PULSE) and clear pulses_sent.
REQ-018 On acceptance, the next state SHALL be HIGH if target>0, otherwise FGAP.
REQ-019 In HIGH, q_serialized SHALL be 1 for exactly PULSE_DURATION cycles, starting the cycle after acceptance (latency 1).
REQ-020 On leaving HIGH, pulses_sent SHALL increment; the next state SHALL be LOW if pulses_sent+1<target, otherwise FGAP.
REQ-021 LOW SHALL hold q_serialized=0 for GAP_DURATION cycles, then return to HIGH.
REQ-022 FGAP SHALL hold q_serialized=0 for FRAME_GAP cycles, then return to IDLE.
REQ-023 busy SHALL be 1 in HIGH, LOW and FGAP, and 0 in IDLE.
REQ-024 q_valid while busy SHALL be ignored; there is no buffering.
REQ-025 start low in HIGH SHALL let the current pulse finish at full width, count it, then go to FGAP.
REQ-026 start low in LOW SHALL go to FGAP on the next edge.
REQ-027 start low in FGAP or IDLE SHALL have no effect other than holding q_ready low.
REQ-028 The phase counter and pulses_sent SHALL never wrap; the maximum target is 2^BUS_WIDTH-1 pulses.

Reset
REQ-029 While rst=0, the block SHALL be in state IDLE with q_serialized=0, busy=0, pulses_sent=0 and all counters cleared, asynchronously.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately, driving q_serialized low in the same instant with no partial pulse completion.
REQ-031 Reset release SHALL be synchronous to clk; the first acceptance is possible on the first rising edge after release.

Configuration
REQ-032 With macro Q_SERIALIZER_DONE_EN defined, output done (1 bit) SHALL pulse high for one cycle on the FGAP->IDLE transition, and be 0 on reset.
REQ-033 Without Q_SERIALIZER_DONE_EN, the done port and its logic SHALL be absent; all other behaviour is identical.

Verification (PULSE_DURATION=3, GAP_DURATION=2, FRAME_GAP=8, Q_PER_PULSE=1, acceptance edge = cycle 0)
REQ-034 q_in=5 accepted -> q_serialized high in cycles 1-3, 6-8, 11-13, 16-18, 21-23; low in 24-31; q_ready=1 at cycle 32; pulses_sent=5; done at cycle 31 (if enabled).
REQ-035 q_in=0 accepted -> no pulse; busy in cycles 1-8; q_ready at cycle 9; pulses_sent=0.
REQ-036 q_in=4 with Q_PER_PULSE=2 -> exactly 2 pulses; pulses_sent=2.
REQ-037 q_in=10 accepted, start dropped at cycle 7 (in HIGH) -> pulse 6-8 completes; FGAP cycles 9-16; pulses_sent=2; q_valid during frame ignored.
REQ-038 rst low at cycle 2 of q_in=5 -> q_serialized=0, busy=0, pulses_sent=0 immediately; new word q_in=1 accepted after release yields a single 3-cycle pulse.
